// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   - arb_state_e  : arbiter FSM states
//   - MAX_BURST_DEF: default maximum beats per burst
//   - PORT_IC/DC   : port indices (0 = instruction cache, 1 = data cache)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    RD_DATA = 2'd2,
    WR_DATA = 2'd3
  } arb_state_e;

  localparam int MAX_BURST_DEF = 16;
  localparam int NUM_PORTS     = 2;
  localparam int PORT_IC       = 0;
  localparam int PORT_DC       = 1;
  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant.
//   clk, resetn : clock, synchronous active-low reset
//   req[1:0]    : request vector
//   update      : commit the current grant as the new last-grant
//   gnt_idx     : index of the winning requester (valid when |req)
// On a tie the requester not granted last wins. Last-grant resets to 1 so
// requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_idx
);

  logic last_q;

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_q;
      default: gnt_idx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn)                last_q <= 1'b1;
    else if (update && (|req))  last_q <= gnt_idx;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-cache (port 0) and data-cache (port 1) burst masters
// onto one shared Avalon-style memory master.
//   clk, resetn        : clock, synchronous active-low reset
//   mN_address/read/write/burstcount/writedata : port N burst request
//   mN_waitrequest     : low only when the granted port's command/beat is taken
//   mN_readdata/readdatavalid : read beats routed back to the granted port
//   av_*               : shared memory master (command, write data, read return)
// One burst is in flight at a time: IDLE -> CMD -> RD_DATA/WR_DATA -> IDLE.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter  int MAX_BURST = MAX_BURST_DEF,
  localparam int BCW       = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  // port 0: instruction cache
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BCW-1:0]    m0_burstcount,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // port 1: data cache
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BCW-1:0]    m1_burstcount,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // shared memory master
  output logic [ADDR_W-1:0] av_address,
  output logic              av_read,
  output logic              av_write,
  output logic [DATA_W-1:0] av_writedata,
  output logic [BCW-1:0]    av_burstcount,
  input  logic              av_waitrequest,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_readdatavalid
);

  // Per-port views as packed arrays so the granted port is a simple index.
  logic [NUM_PORTS-1:0]             p_rd, p_wr, p_req;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] p_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] p_wdata;
  logic [NUM_PORTS-1:0][BCW-1:0]    p_bc;
  logic [NUM_PORTS-1:0]             m_wait, m_rdv;
  logic [NUM_PORTS-1:0][DATA_W-1:0] m_rdata;

  assign p_rd    = {m1_read, m0_read};
  assign p_wr    = {m1_write, m0_write};
  assign p_req   = p_rd | p_wr;
  assign p_addr  = {m1_address, m0_address};
  assign p_wdata = {m1_writedata, m0_writedata};
  assign p_bc    = {m1_burstcount, m0_burstcount};

  assign m0_waitrequest   = m_wait[PORT_IC];
  assign m1_waitrequest   = m_wait[PORT_DC];
  assign m0_readdatavalid = m_rdv[PORT_IC];
  assign m1_readdatavalid = m_rdv[PORT_DC];
  assign m0_readdata      = m_rdata[PORT_IC];
  assign m1_readdata      = m_rdata[PORT_DC];

  arb_state_e     state_q, state_d;
  logic           gnt_q, gnt_d;
  logic [BCW-1:0] burst_q, burst_d;
  logic [BCW-1:0] cnt_q, cnt_d, cnt_inc;
  logic           arb_idx, arb_en;
  logic           g_rd, g_wr;

  // 0 beats means 1; anything beyond MAX_BURST is clamped.
  function automatic logic [BCW-1:0] norm_bc(input logic [BCW-1:0] bc);
    if (bc == '0)                 return BCW'(1);
    else if (bc > BCW'(MAX_BURST)) return BCW'(MAX_BURST);
    else                          return bc;
  endfunction

  assign arb_en = (state_q == IDLE) && (|p_req);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .resetn  (resetn),
    .req     (p_req),
    .update  (arb_en),
    .gnt_idx (arb_idx)
  );

  // Read wins when a port raises both read and write.
  assign g_rd    = p_rd[gnt_q];
  assign g_wr    = p_wr[gnt_q] & ~p_rd[gnt_q];
  assign cnt_inc = cnt_q + BCW'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    burst_d       = burst_q;
    cnt_d         = cnt_q;
    av_address    = '0;
    av_read       = 1'b0;
    av_write      = 1'b0;
    av_writedata  = '0;
    av_burstcount = '0;
    m_wait        = '1;
    m_rdv         = '0;
    m_rdata       = '0;

    case (state_q)
      IDLE: begin
        if (|p_req) begin
          gnt_d   = arb_idx;
          burst_d = norm_bc(p_bc[arb_idx]);
          cnt_d   = '0;
          state_d = CMD;
        end
      end

      CMD: begin
        av_address    = p_addr[gnt_q];
        av_burstcount = burst_q;
        av_writedata  = p_wdata[gnt_q];
        av_read       = g_rd;
        av_write      = g_wr;
        if (!av_waitrequest && (g_rd || g_wr)) begin
          m_wait[gnt_q] = 1'b0;
          if (g_rd) begin
            cnt_d   = '0;
            state_d = RD_DATA;
          end else if (burst_q == BCW'(1)) begin
            // single-beat write: the command cycle carried the only beat
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = BCW'(1);
            state_d = WR_DATA;
          end
        end
      end

      RD_DATA: begin
        if (av_readdatavalid) begin
          m_rdv[gnt_q]   = 1'b1;
          m_rdata[gnt_q] = av_readdata;
          cnt_d          = cnt_inc;
          if (cnt_inc == burst_q) state_d = IDLE;
        end
      end

      WR_DATA: begin
        av_write     = p_wr[gnt_q];
        av_writedata = p_wdata[gnt_q];
        if (p_wr[gnt_q] && !av_waitrequest) begin
          m_wait[gnt_q] = 1'b0;
          cnt_d         = cnt_inc;
          if (cnt_inc == burst_q) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset is synchronous, so the state register may still hold a burst
    // state while resetn is low; keep the bus quiet regardless.
    if (!resetn) begin
      av_address    = '0;
      av_read       = 1'b0;
      av_write      = 1'b0;
      av_writedata  = '0;
      av_burstcount = '0;
      m_wait        = '1;
      m_rdv         = '0;
      m_rdata       = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [4:0]  m0_burstcount, m1_burstcount;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [31:0] av_address, av_writedata, av_readdata;
  logic        av_read, av_write, av_waitrequest, av_readdatavalid;
  logic [4:0]  av_burstcount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_burstcount(m1_burstcount), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_burstcount(av_burstcount),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .av_readdatavalid(av_readdatavalid)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdv_vec();
    return {30'd0, m1_readdatavalid, m0_readdatavalid};
  endfunction

  function automatic logic [31:0] wait_vec();
    return {30'd0, m1_waitrequest, m0_waitrequest};
  endfunction

  // Deliver n read beats, one per cycle, and check routing to port p.
  task automatic rd_beats(input int p, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      av_readdatavalid = 1'b1;
      av_readdata      = base + 32'(i);
      #1;
      chk("rd_vld", rdv_vec(), (p != 0) ? 32'd2 : 32'd1);
      chk("rd_data", (p != 0) ? m1_readdata : m0_readdata, base + 32'(i));
      step();
    end
    av_readdatavalid = 1'b0;
  endtask

  // Serve a pending single-beat read expected to be granted to port p.
  task automatic rd1(input int p, input logic [31:0] a, input logic [31:0] d);
    step();
    #1;
    chk("arb_addr", av_address, a);
    chk("arb_wait", wait_vec(), (p != 0) ? 32'd1 : 32'd2);
    step();
    if (p == 0) m0_read = 1'b0;
    else        m1_read = 1'b0;
    rd_beats(p, 1, d);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_burstcount = '0; m1_burstcount = '0;
    av_waitrequest = 1'b0; av_readdata = '0; av_readdatavalid = 1'b0;

    // reset state
    step();
    #1;
    chk("rst_av_read", {31'd0, av_read}, 32'd0);
    chk("rst_av_write", {31'd0, av_write}, 32'd0);
    chk("rst_av_addr", av_address, 32'd0);
    chk("rst_wait", wait_vec(), 32'd3);
    chk("rst_rdv", rdv_vec(), 32'd0);

    // port 0 read burst of 16
    step();
    resetn = 1'b1;
    m0_read = 1'b1; m0_address = 32'h0000_1000; m0_burstcount = 5'd16;
    #1;
    chk("idle_av_read", {31'd0, av_read}, 32'd0);
    chk("idle_wait", wait_vec(), 32'd3);
    step();
    #1;
    chk("cmd_av_read", {31'd0, av_read}, 32'd1);
    chk("cmd_av_write", {31'd0, av_write}, 32'd0);
    chk("cmd_addr", av_address, 32'h1000);
    chk("cmd_bc", {27'd0, av_burstcount}, 32'd16);
    chk("cmd_wait", wait_vec(), 32'd2);
    step();
    m0_read = 1'b0;
    #1;
    chk("rd_one_cycle", {31'd0, av_read}, 32'd0);
    rd_beats(0, 16, 32'hD000);
    av_readdatavalid = 1'b1;
    #1;
    chk("stray_rdv", rdv_vec(), 32'd0);
    av_readdatavalid = 1'b0;

    // simultaneous requests alternate, port 0 first after reset
    do_reset();
    m0_read = 1'b1; m1_read = 1'b1;
    m0_address = 32'h100; m1_address = 32'h200;
    m0_burstcount = 5'd1; m1_burstcount = 5'd1;
    rd1(0, 32'h100, 32'h11);
    rd1(1, 32'h200, 32'h22);
    m0_read = 1'b1; m1_read = 1'b1;
    rd1(0, 32'h100, 32'h33);
    rd1(1, 32'h200, 32'h44);

    // port 1 write of 4 beats, 3 stall cycles on the command
    av_waitrequest = 1'b1;
    m1_write = 1'b1; m1_address = 32'h300; m1_burstcount = 5'd4;
    m1_writedata = 32'hA0;
    step();
    #1;
    chk("wr_cmd_write", {31'd0, av_write}, 32'd1);
    chk("wr_cmd_read", {31'd0, av_read}, 32'd0);
    chk("wr_cmd_addr", av_address, 32'h300);
    chk("wr_cmd_bc", {27'd0, av_burstcount}, 32'd4);
    chk("wr_stall1", wait_vec(), 32'd3);
    step();
    #1;
    chk("wr_stall2", wait_vec(), 32'd3);
    step();
    #1;
    chk("wr_stall3", wait_vec(), 32'd3);
    step();
    av_waitrequest = 1'b0;
    #1;
    chk("wr_b0_wait", wait_vec(), 32'd1);
    chk("wr_b0_data", av_writedata, 32'hA0);
    step();
    m1_writedata = 32'hA1; av_waitrequest = 1'b1;
    #1;
    chk("wr_data_write", {31'd0, av_write}, 32'd1);
    chk("wr_b1_stall", wait_vec(), 32'd3);
    step();
    av_waitrequest = 1'b0;
    #1;
    chk("wr_b1_wait", wait_vec(), 32'd1);
    chk("wr_b1_data", av_writedata, 32'hA1);
    step();
    m1_writedata = 32'hA2;
    #1;
    chk("wr_b2_wait", wait_vec(), 32'd1);
    chk("wr_b2_data", av_writedata, 32'hA2);
    step();
    m1_writedata = 32'hA3;
    #1;
    chk("wr_b3_wait", wait_vec(), 32'd1);
    chk("wr_b3_data", av_writedata, 32'hA3);
    step();
    #1;
    chk("wr_done_write", {31'd0, av_write}, 32'd0);
    chk("wr_done_wait", wait_vec(), 32'd3);
    m1_write = 1'b0;

    // burstcount 0 treated as 1
    m0_read = 1'b1; m0_address = 32'h400; m0_burstcount = 5'd0;
    step();
    #1;
    chk("bc0_bc", {27'd0, av_burstcount}, 32'd1);
    chk("bc0_addr", av_address, 32'h400);
    step();
    m0_read = 1'b0;
    rd_beats(0, 1, 32'hB0);
    av_readdatavalid = 1'b1;
    #1;
    chk("bc0_idle_rdv", rdv_vec(), 32'd0);
    chk("bc0_idle_read", {31'd0, av_read}, 32'd0);
    av_readdatavalid = 1'b0;

    // burstcount 20 clamped to 16, reset after 5 beats
    m0_read = 1'b1; m0_address = 32'h800; m0_burstcount = 5'd20;
    step();
    #1;
    chk("bc20_bc", {27'd0, av_burstcount}, 32'd16);
    step();
    m0_read = 1'b0;
    rd_beats(0, 5, 32'hC0);
    resetn = 1'b0;
    av_readdatavalid = 1'b1; av_readdata = 32'hC5;
    #1;
    chk("midrst_rdv", rdv_vec(), 32'd0);
    chk("midrst_wait", wait_vec(), 32'd3);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      av_readdata = 32'hC6 + 32'(i);
      #1;
      chk("postrst_rdv", rdv_vec(), 32'd0);
      step();
    end
    av_readdatavalid = 1'b0;

    // new request after reset served normally
    m0_read = 1'b1; m0_address = 32'h900; m0_burstcount = 5'd2;
    step();
    #1;
    chk("new_read", {31'd0, av_read}, 32'd1);
    chk("new_addr", av_address, 32'h900);
    step();
    m0_read = 1'b0;
    rd_beats(0, 2, 32'hE0);
    #1;
    chk("new_done_read", {31'd0, av_read}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
